// File: rtl/multi_seven_seg_scan_if.sv
// Bus between a display scanner and its driver: per-digit patterns and controls in,
// the multiplexed segment/anode pins out.
interface multi_seven_seg_scan_if #(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned BRIGHT_W = 2
);
  logic [7*N_DIGITS-1:0] seg_in;      // active-low, digit k at [7k+6:7k]
  logic [N_DIGITS-1:0]   dp_in;       // active-low decimal points
  logic [N_DIGITS-1:0]   blink_mask;  // 1 = digit goes dark in blink off-phase
  logic [BRIGHT_W-1:0]   bright;      // all-ones = full on-time
  logic                  blank;       // 1 = whole display dark
  logic [6:0]            seg;         // shared segment bus, active-low
  logic                  dp;          // shared decimal point, active-low
  logic [N_DIGITS-1:0]   an;          // anode enables, active-low
  logic                  frame_start; // one-cycle pulse as digit 0 slot starts

  modport master (
    output seg_in, dp_in, blink_mask, bright, blank,
    input  seg, dp, an, frame_start
  );

  modport slave (
    input  seg_in, dp_in, blink_mask, bright, blank,
    output seg, dp, an, frame_start
  );
endinterface

// File: rtl/multi_seven_seg_scan.sv
// Time-division scanner for an N-digit common-anode seven-segment display with
// refresh prescaler, brightness PWM, dead time, per-digit blink and global blank.
module multi_seven_seg_scan #(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned DIV          = 1024,
  parameter int unsigned BRIGHT_W     = 2,
  parameter int unsigned DEAD         = 2,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input logic                   clk,
  input logic                   rst,
  multi_seven_seg_scan_if.slave bus
);

  localparam int unsigned PreW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DigW = $clog2(N_DIGITS);
  localparam int unsigned BlkW = $clog2(BLINK_FRAMES + 1);
  localparam int unsigned Step = DIV >> BRIGHT_W;

  logic [PreW-1:0]     pre_q, pre_d;
  logic [DigW-1:0]     digit_q, digit_d;
  logic [BlkW-1:0]     blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                fs_q, fs_d;

  logic        slot_end, last_digit, lit;
  int unsigned on_limit;

  // Scan counters: prescaler, digit index and blink frame counter.
  always_comb begin
    slot_end      = (pre_q == PreW'(DIV - 1));
    last_digit    = (digit_q == DigW'(N_DIGITS - 1));
    pre_d         = slot_end ? '0 : pre_q + 1'b1;
    digit_d       = digit_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (slot_end) begin
      digit_d = last_digit ? '0 : digit_q + 1'b1;
      if (last_digit) begin
        if (blink_cnt_q == BlkW'(BLINK_FRAMES - 1)) begin
          blink_cnt_d   = '0;
          blink_phase_d = ~blink_phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end
    end
  end

  // Lit decision and next pin values; phase<=bright is the same as pre_cnt<(bright+1)*step.
  always_comb begin
    on_limit = (32'(bus.bright) + 32'd1) * Step;
    lit      = !bus.blank
            && (32'(pre_q) >= DEAD)
            && (32'(pre_q) < on_limit)
            && !(bus.blink_mask[digit_q] && blink_phase_q);
    an_d     = lit ? ~(N_DIGITS'(1) << digit_q) : '1;
    seg_d    = lit ? bus.seg_in[7*digit_q +: 7] : 7'h7F;
    dp_d     = lit ? bus.dp_in[digit_q] : 1'b1;
    fs_d     = (pre_q == '0) && (digit_q == '0);
  end

  // State and registered outputs; reset forces the display dark without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q         <= '0;
      digit_q       <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      an_q          <= '1;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      fs_q          <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      digit_q       <= digit_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      fs_q          <= fs_d;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_multi_seven_seg_scan.sv
// Bench for multi_seven_seg_scan: a 4-digit and an 8-digit instance run side by side
// against a time-based reference model.
module tb_multi_seven_seg_scan;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint ticks  = 0;  // clock edges since the last reset release

  multi_seven_seg_scan_if #(.N_DIGITS(4), .BRIGHT_W(2)) ia ();
  multi_seven_seg_scan_if #(.N_DIGITS(8), .BRIGHT_W(2)) ib ();

  multi_seven_seg_scan #(
    .N_DIGITS(4), .DIV(16), .BRIGHT_W(2), .DEAD(1), .BLINK_FRAMES(2)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(ia)
  );

  multi_seven_seg_scan #(
    .N_DIGITS(8), .DIV(32), .BRIGHT_W(2), .DEAD(2), .BLINK_FRAMES(1)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(ib)
  );

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } exp_t;

  // Pins expected after the edge taken with k edges already elapsed since release.
  function automatic exp_t model(input int n, input int div, input int bw, input int dead,
                                 input int bf, input longint k, input logic [55:0] segv,
                                 input logic [7:0] dpv, input logic [7:0] maskv,
                                 input int br, input bit blk);
    exp_t   e;
    int     pre, dig, step;
    longint frame;
    bit     ph, lit;
    pre   = int'(k % div);
    dig   = int'((k / div) % n);
    frame = k / (n * div);
    ph    = ((frame / bf) % 2) == 1;
    step  = div >> bw;
    lit   = !blk && (pre >= dead) && ((pre / step) <= br) && !(maskv[dig] && ph);
    e.an  = lit ? ~(8'd1 << dig) : 8'hFF;
    e.seg = lit ? segv[7*dig +: 7] : 7'h7F;
    e.dp  = lit ? dpv[dig] : 1'b1;
    e.fs  = (pre == 0) && (dig == 0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h tick=%0d", tag, got, exp, ticks);
    end
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_a_an"}, 32'(ia.an), 32'h0000_000F);
    check({tag, "_a_seg"}, 32'(ia.seg), 32'h0000_007F);
    check({tag, "_a_dp"}, 32'(ia.dp), 32'd1);
    check({tag, "_a_fs"}, 32'(ia.frame_start), 32'd0);
    check({tag, "_b_an"}, 32'(ib.an), 32'h0000_00FF);
    check({tag, "_b_seg"}, 32'(ib.seg), 32'h0000_007F);
    check({tag, "_b_dp"}, 32'(ib.dp), 32'd1);
    check({tag, "_b_fs"}, 32'(ib.frame_start), 32'd0);
  endtask

  // One clock: predict from the inputs held across the edge, then compare just after it.
  task automatic step(input string tag);
    exp_t ea, eb;
    ea = model(4, 16, 2, 1, 2, ticks, 56'(ia.seg_in), 8'(ia.dp_in), 8'(ia.blink_mask),
               int'(ia.bright), ia.blank);
    eb = model(8, 32, 2, 2, 1, ticks, ib.seg_in, ib.dp_in, ib.blink_mask,
               int'(ib.bright), ib.blank);
    @(posedge clk);
    #1;
    ticks++;
    check({tag, "_a_an"}, 32'(ia.an), 32'(ea.an[3:0]));
    check({tag, "_a_seg"}, 32'(ia.seg), 32'(ea.seg));
    check({tag, "_a_dp"}, 32'(ia.dp), 32'(ea.dp));
    check({tag, "_a_fs"}, 32'(ia.frame_start), 32'(ea.fs));
    check({tag, "_b_an"}, 32'(ib.an), 32'(eb.an));
    check({tag, "_b_seg"}, 32'(ib.seg), 32'(eb.seg));
    check({tag, "_b_dp"}, 32'(ib.dp), 32'(eb.dp));
    check({tag, "_b_fs"}, 32'(ib.frame_start), 32'(eb.fs));
    check({tag, "_a_onecold"}, 32'($countones(~ia.an) <= 1), 32'd1);
    check({tag, "_b_onecold"}, 32'($countones(~ib.an) <= 1), 32'd1);
  endtask

  task automatic rand_inputs(input int blank_pct);
    ia.seg_in     = 28'($urandom);
    ia.dp_in      = 4'($urandom);
    ia.blink_mask = 4'($urandom);
    ia.bright     = 2'($urandom);
    ia.blank      = ($urandom_range(99) < blank_pct);
    ib.seg_in     = 56'({$urandom, $urandom});
    ib.dp_in      = 8'($urandom);
    ib.blink_mask = 8'($urandom);
    ib.bright     = 2'($urandom);
    ib.blank      = ($urandom_range(99) < blank_pct);
  endtask

  task automatic set_both(input logic [3:0] mask_a, input logic [7:0] mask_b,
                          input logic [1:0] br, input logic blk);
    ia.blink_mask = mask_a;
    ib.blink_mask = mask_b;
    ia.bright     = br;
    ib.bright     = br;
    ia.blank      = blk;
    ib.blank      = blk;
  endtask

  initial begin
    bit found;
    rst           = 1'b1;
    ia.seg_in     = {7'h01, 7'h02, 7'h04, 7'h08};
    ia.dp_in      = 4'b1010;
    ib.seg_in     = {7'h11, 7'h22, 7'h33, 7'h44, 7'h55, 7'h66, 7'h77, 7'h0F};
    ib.dp_in      = 8'b0110_1001;
    set_both(4'b0000, 8'h00, 2'd3, 1'b0);

    // Reset held across edges keeps everything dark.
    repeat (3) @(posedge clk);
    #1;
    check_dark("reset");
    @(negedge clk);
    rst   = 1'b0;
    ticks = 0;

    // Scan order at full brightness, two full frames.
    for (int i = 0; i < 128; i++) step("scan");

    // Brightness levels.
    set_both(4'b0000, 8'h00, 2'd0, 1'b0);
    for (int i = 0; i < 128; i++) step("bright0");
    set_both(4'b0000, 8'h00, 2'd2, 1'b0);
    for (int i = 0; i < 128; i++) step("bright2");

    // Blink on one digit across several half-periods.
    set_both(4'b0010, 8'b0000_0100, 2'd3, 1'b0);
    for (int i = 0; i < 400; i++) step("blink");

    // Blank, then release.
    set_both(4'b0010, 8'b0000_0100, 2'd3, 1'b1);
    for (int i = 0; i < 100; i++) step("blank");
    set_both(4'b0000, 8'h00, 2'd3, 1'b0);
    for (int i = 0; i < 64; i++) step("unblank");

    // Random inputs changing every cycle.
    for (int i = 0; i < 2000; i++) begin
      rand_inputs(10);
      step("rand");
    end

    // Async reset between edges while digit 2 of the 4-digit instance is at pre_cnt 7.
    set_both(4'b0000, 8'h00, 2'd3, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      if ((ticks % 64) == 39) found = 1'b1;
      else step("seek");
    end
    check("seek_found", 32'(found), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_dark("async_rst");
    repeat (2) @(posedge clk);
    #1;
    check_dark("rst_hold");
    @(negedge clk);
    rst   = 1'b0;
    ticks = 0;
    for (int i = 0; i < 600; i++) begin
      if (i >= 100) rand_inputs(5);
      step("post_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
